// File: rtl/vigna_pkg.sv
// Shared encodings for the vigna bus RAM: FSM states, requester port ids and
// the width of the wait-cycle counter.
package vigna_pkg;

  localparam int unsigned LAT_W = 4;

  typedef enum logic [1:0] {
    StIdle = 2'd0,
    StWait = 2'd1,
    StResp = 2'd2
  } state_e;

  typedef enum logic {
    PORT_I = 1'b0,
    PORT_D = 1'b1
  } port_e;

endpackage

// File: rtl/vigna_bus_ram_array.sv
// Single-port synchronous word RAM with per-byte write enables and no reset.
// A read (enable with no byte lanes set) updates the registered read data.
module vigna_bus_ram_array #(
  parameter int unsigned DEPTH_WORDS = 1024,
  parameter int unsigned AW          = $clog2(DEPTH_WORDS)
) (
  input  logic          clk,
  input  logic          i_en,
  input  logic [3:0]    i_we,
  input  logic [AW-1:0] i_addr,
  input  logic [31:0]   i_wdata,
  output logic [31:0]   o_rdata
);

  logic [31:0] r_mem [DEPTH_WORDS];
  logic [31:0] r_rdata;

  always_ff @(posedge clk) begin
    if (i_en) begin
      if (i_we == 4'b0000) begin
        r_rdata <= r_mem[i_addr];
      end
      for (int k = 0; k < 4; k++) begin
        if (i_we[k]) begin
          r_mem[i_addr][8*k +: 8] <= i_wdata[8*k +: 8];
        end
      end
    end
  end

  assign o_rdata = r_rdata;

endmodule

// File: rtl/vigna_bus_ram.sv
// Dual-responder (instruction/data) bus RAM: round-robin arbitration, one access
// in flight, fixed wait latency, out-of-range accesses complete with err.
module vigna_bus_ram
  import vigna_pkg::*;
#(
  parameter int unsigned DEPTH_WORDS = 1024,
  parameter logic [31:0] BASE_ADDR   = 32'h0000_0000,
  parameter int unsigned LATENCY     = 1
) (
  input  logic        clk,
  input  logic        resetn,
  input  logic        i_valid,
  input  logic [31:0] i_addr,
  input  logic [31:0] i_wdata,
  input  logic [3:0]  i_wstrb,
  output logic        i_ready,
  output logic [31:0] i_rdata,
  input  logic        d_valid,
  input  logic [31:0] d_addr,
  input  logic [31:0] d_wdata,
  input  logic [3:0]  d_wstrb,
  output logic        d_ready,
  output logic [31:0] d_rdata,
  output logic        err
);

  localparam int unsigned AW = $clog2(DEPTH_WORDS);

  state_e           r_state, w_state_nxt;
  logic [LAT_W-1:0] r_cnt, w_cnt_nxt;
  port_e            r_port, r_last, w_sel;
  logic [AW-1:0]    r_idx, w_req_idx, w_mem_idx;
  logic             r_in_range, w_req_in_range;
  logic [31:0]      r_wdata, w_req_wdata;
  logic [3:0]       r_wstrb, w_req_wstrb;
  logic [31:0]      r_i_rdata, r_d_rdata;
  logic [31:0]      w_req_addr, w_req_off, w_mem_rdata, w_resp_data;
  logic             w_any, w_grant, w_resp, w_is_read, w_rd_go, w_wr_go;
  logic             w_unused;

  // Tie goes to the port that was not granted last.
  always_comb begin
    w_sel = PORT_D;
    if (i_valid && d_valid) begin
      w_sel = (r_last == PORT_I) ? PORT_D : PORT_I;
    end else if (i_valid) begin
      w_sel = PORT_I;
    end
  end

  assign w_any          = i_valid | d_valid;
  assign w_grant        = (r_state == StIdle) && w_any;
  assign w_req_addr     = (w_sel == PORT_I) ? i_addr  : d_addr;
  assign w_req_wdata    = (w_sel == PORT_I) ? i_wdata : d_wdata;
  assign w_req_wstrb    = (w_sel == PORT_I) ? i_wstrb : d_wstrb;
  // Wrapped subtraction lands in the upper bits, so it counts as out of range.
  assign w_req_off      = w_req_addr - BASE_ADDR;
  assign w_req_idx      = w_req_off[AW+1:2];
  assign w_req_in_range = (w_req_off[31:AW+2] == '0);
  assign w_unused       = ^w_req_off[1:0];

  always_comb begin
    w_state_nxt = r_state;
    w_cnt_nxt   = r_cnt;
    unique case (r_state)
      StIdle: begin
        if (w_any) begin
          w_cnt_nxt   = LAT_W'(LATENCY);
          w_state_nxt = (LATENCY == 0) ? StResp : StWait;
        end
      end
      StWait: begin
        w_cnt_nxt = r_cnt - 1'b1;
        if (r_cnt == LAT_W'(1)) begin
          w_state_nxt = StResp;
        end
      end
      StResp:  w_state_nxt = StIdle;
      default: w_state_nxt = StIdle;
    endcase
  end

  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      r_state    <= StIdle;
      r_cnt      <= '0;
      r_last     <= PORT_D;
      r_port     <= PORT_I;
      r_idx      <= '0;
      r_in_range <= 1'b0;
      r_wdata    <= '0;
      r_wstrb    <= '0;
      r_i_rdata  <= '0;
      r_d_rdata  <= '0;
    end else begin
      r_state <= w_state_nxt;
      r_cnt   <= w_cnt_nxt;
      if (w_grant) begin
        r_last     <= w_sel;
        r_port     <= w_sel;
        r_idx      <= w_req_idx;
        r_in_range <= w_req_in_range;
        r_wdata    <= w_req_wdata;
        r_wstrb    <= w_req_wstrb;
      end
      if (w_resp && w_is_read) begin
        if (r_port == PORT_I) r_i_rdata <= w_resp_data;
        else                  r_d_rdata <= w_resp_data;
      end
    end
  end

  assign w_resp      = (r_state == StResp);
  assign w_is_read   = (r_wstrb == 4'b0000);
  assign w_resp_data = r_in_range ? w_mem_rdata : 32'h0;

  always_comb begin
    i_ready = w_resp && (r_port == PORT_I);
    d_ready = w_resp && (r_port == PORT_D);
    err     = w_resp && !r_in_range;
    i_rdata = r_i_rdata;
    d_rdata = r_d_rdata;
    if (w_resp && w_is_read) begin
      if (r_port == PORT_I) i_rdata = w_resp_data;
      else                  d_rdata = w_resp_data;
    end
  end

  // Read launches on the edge entering RESP; write commits on the edge leaving it.
  assign w_rd_go   = (LATENCY == 0) ? w_grant : ((r_state == StWait) && (r_cnt == LAT_W'(1)));
  assign w_wr_go   = w_resp && !w_is_read && r_in_range;
  assign w_mem_idx = (r_state == StIdle) ? w_req_idx : r_idx;

  vigna_bus_ram_array #(
    .DEPTH_WORDS(DEPTH_WORDS),
    .AW         (AW)
  ) u_array (
    .clk    (clk),
    .i_en   (w_rd_go | w_wr_go),
    .i_we   (w_wr_go ? r_wstrb : 4'b0000),
    .i_addr (w_mem_idx),
    .i_wdata(r_wdata),
    .o_rdata(w_mem_rdata)
  );

endmodule

// File: tb/tb_vigna_bus_ram.sv
// Randomized bench for vigna_bus_ram: three instances (LATENCY 1, 0, 3) checked
// against a word-array model with expected response timing from the latency rule.
module tb_vigna_bus_ram;

  localparam int NU = 3;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic        rn  [NU];
  logic        iv  [NU], dv [NU];
  logic [31:0] ia  [NU], iw [NU], da [NU], dw [NU];
  logic [3:0]  is  [NU], ds [NU];
  logic        ir  [NU], dr [NU], er [NU];
  logic [31:0] ird [NU], drd [NU];

  logic [31:0] ref_mem [NU][64];
  int n_tests = 0;
  int n_fail  = 0;

  for (genvar g = 0; g < NU; g++) begin : g_dut
    vigna_bus_ram #(
      .DEPTH_WORDS(1024),
      .BASE_ADDR  (32'h0000_0000),
      .LATENCY    ((g == 0) ? 1 : ((g == 1) ? 0 : 3))
    ) u_dut (
      .clk    (clk),
      .resetn (rn[g]),
      .i_valid(iv[g]),
      .i_addr (ia[g]),
      .i_wdata(iw[g]),
      .i_wstrb(is[g]),
      .i_ready(ir[g]),
      .i_rdata(ird[g]),
      .d_valid(dv[g]),
      .d_addr (da[g]),
      .d_wdata(dw[g]),
      .d_wstrb(ds[g]),
      .d_ready(dr[g]),
      .d_rdata(drd[g]),
      .err    (er[g])
    );
  end

  function automatic int lat_of(int u);
    return (u == 0) ? 1 : ((u == 1) ? 0 : 3);
  endfunction

  function automatic logic rdy(int u, bit p);
    return p ? dr[u] : ir[u];
  endfunction

  function automatic logic [31:0] rdat(int u, bit p);
    return p ? drd[u] : ird[u];
  endfunction

  task automatic check_eq(string tag, logic [31:0] got, logic [31:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h, expected %h", tag, got, exp);
    end
  endtask

  task automatic drive(int u, bit p, logic v, logic [31:0] a, logic [31:0] w, logic [3:0] s);
    if (!p) begin
      iv[u] = v; ia[u] = a; iw[u] = w; is[u] = s;
    end else begin
      dv[u] = v; da[u] = a; dw[u] = w; ds[u] = s;
    end
  endtask

  // One access from an idle DUT, starting and ending on a falling edge.
  task automatic do_access(int u, bit p, logic [31:0] a, logic [31:0] w, logic [3:0] s, bit drop);
    logic [31:0] own_prev, oth_prev, exp;
    bit inr;
    int idx, n;
    bit seen;
    own_prev = rdat(u, p);
    oth_prev = rdat(u, !p);
    inr = (a >> 2) < 32'd1024;
    idx = int'(a >> 2);
    if (s == 4'h0) exp = inr ? ref_mem[u][idx] : 32'h0;
    else           exp = own_prev;
    drive(u, p, 1'b1, a, w, s);
    seen = 1'b0;
    n = 0;
    while (!seen && n < 40) begin
      @(negedge clk);
      n++;
      if (rdy(u, p)) seen = 1'b1;
      else if (drop && n == 1) drive(u, p, 1'b0, a, w, s);
    end
    check_eq($sformatf("u%0d p%0d ready latency", u, p), n, lat_of(u) + 1);
    check_eq($sformatf("u%0d p%0d rdata @%h", u, p, a), rdat(u, p), exp);
    check_eq($sformatf("u%0d err @%h", u, a), 32'(er[u]), 32'(!inr));
    check_eq($sformatf("u%0d other rdata held", u), rdat(u, !p), oth_prev);
    drive(u, p, 1'b0, a, w, s);
    @(negedge clk);
    check_eq($sformatf("u%0d ready single pulse", u), 32'(rdy(u, p)), 0);
    check_eq($sformatf("u%0d err single pulse", u), 32'(er[u]), 0);
    if (s != 4'h0 && inr) begin
      for (int k = 0; k < 4; k++) begin
        if (s[k]) ref_mem[u][idx][8*k +: 8] = w[8*k +: 8];
      end
    end
  endtask

  task automatic do_reset(int u);
    @(negedge clk);
    #2 rn[u] = 1'b0;
    #1;
    check_eq($sformatf("u%0d rst i_ready", u), 32'(ir[u]), 0);
    check_eq($sformatf("u%0d rst d_ready", u), 32'(dr[u]), 0);
    check_eq($sformatf("u%0d rst err", u), 32'(er[u]), 0);
    check_eq($sformatf("u%0d rst i_rdata", u), ird[u], 0);
    check_eq($sformatf("u%0d rst d_rdata", u), drd[u], 0);
    @(negedge clk);
    rn[u] = 1'b1;
  endtask

  // Reads with valid held; each access occupies one IDLE, LATENCY WAIT and one RESP cycle.
  task automatic stream(int u, bit use_i, bit use_d, int total);
    int n, k, ki, kd, lat;
    bit exp_p;
    lat = lat_of(u);
    n = 0; k = 0; ki = 0; kd = 0;
    exp_p = use_i ? 1'b0 : 1'b1;
    drive(u, 1'b0, use_i, 32'h0, 32'h0, 4'h0);
    drive(u, 1'b1, use_d, 32'h40, 32'h0, 4'h0);
    while (k < total && n < 200) begin
      @(negedge clk);
      n++;
      if (ir[u] || dr[u]) begin
        check_eq($sformatf("u%0d stream one ready", u), 32'(ir[u] & dr[u]), 0);
        check_eq($sformatf("u%0d stream grant %0d is d", u, k), 32'(dr[u]), 32'(exp_p));
        check_eq($sformatf("u%0d stream time %0d", u, k), n, (lat + 1) + k * (lat + 2));
        if (dr[u]) begin
          check_eq($sformatf("u%0d stream d_rdata", u), drd[u], ref_mem[u][16 + kd]);
          kd++;
          drive(u, 1'b1, 1'b1, 32'(64 + 4 * kd), 32'h0, 4'h0);
        end else begin
          check_eq($sformatf("u%0d stream i_rdata", u), ird[u], ref_mem[u][ki]);
          ki++;
          drive(u, 1'b0, 1'b1, 32'(4 * ki), 32'h0, 4'h0);
        end
        k++;
        if (use_i && use_d) exp_p = !exp_p;
      end
    end
    check_eq($sformatf("u%0d stream count", u), k, total);
    drive(u, 1'b0, 1'b0, 32'h0, 32'h0, 4'h0);
    drive(u, 1'b1, 1'b0, 32'h0, 32'h0, 4'h0);
    @(negedge clk);
  endtask

  task automatic reset_mid_wait();
    logic [31:0] old;
    int hits;
    old = ref_mem[2][5];
    drive(2, 1'b1, 1'b1, 32'h14, ~old, 4'hF);
    @(negedge clk);
    @(negedge clk);
    rn[2] = 1'b0;
    #1;
    check_eq("mid-wait rst d_ready", 32'(dr[2]), 0);
    drive(2, 1'b1, 1'b0, 32'h14, ~old, 4'hF);
    hits = 0;
    repeat (4) begin
      @(negedge clk);
      if (dr[2] || ir[2] || er[2]) hits++;
    end
    check_eq("mid-wait no ready after reset", hits, 0);
    rn[2] = 1'b1;
    do_access(2, 1'b1, 32'h14, 32'h0, 4'h0, 1'b0);
    check_eq("mid-wait word unchanged", drd[2], old);
  endtask

  initial begin
    #1000000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    logic [31:0] a;
    logic [3:0]  s;
    bit          p;
    for (int u = 0; u < NU; u++) begin
      rn[u] = 1'b0;
      drive(u, 1'b0, 1'b0, 32'h0, 32'h0, 4'h0);
      drive(u, 1'b1, 1'b0, 32'h0, 32'h0, 4'h0);
    end
    repeat (2) @(negedge clk);
    for (int u = 0; u < NU; u++) begin
      check_eq($sformatf("u%0d reset i_ready", u), 32'(ir[u]), 0);
      check_eq($sformatf("u%0d reset d_ready", u), 32'(dr[u]), 0);
      check_eq($sformatf("u%0d reset err", u), 32'(er[u]), 0);
      check_eq($sformatf("u%0d reset i_rdata", u), ird[u], 0);
      check_eq($sformatf("u%0d reset d_rdata", u), drd[u], 0);
      rn[u] = 1'b1;
    end
    @(negedge clk);

    for (int u = 0; u < NU; u++) begin
      for (int w = 0; w < 64; w++) begin
        do_access(u, 1'(w % 2), 32'(4 * w), $urandom, 4'hF, 1'b0);
      end
    end

    do_access(0, 1'b1, 32'h10, 32'hDEAD_BEEF, 4'hF, 1'b0);
    do_access(0, 1'b0, 32'h10, 32'h0, 4'h0, 1'b0);
    check_eq("deadbeef readback", ird[0], 32'hDEAD_BEEF);

    do_access(0, 1'b1, 32'h20, 32'h1122_3344, 4'hF, 1'b0);
    do_access(0, 1'b1, 32'h20, 32'hAABB_CCDD, 4'b0101, 1'b0);
    do_access(0, 1'b0, 32'h20, 32'h0, 4'h0, 1'b0);
    check_eq("byte strobe merge", ird[0], 32'h11BB_33DD);

    do_access(0, 1'b1, 32'h1000, 32'h0, 4'h0, 1'b0);
    check_eq("out-of-range read zero", drd[0], 32'h0);
    do_access(0, 1'b1, 32'h1000, 32'hCAFE_F00D, 4'hF, 1'b0);
    do_access(0, 1'b1, 32'h0, 32'h0, 4'h0, 1'b0);

    do_reset(0);
    stream(0, 1'b1, 1'b1, 4);
    stream(1, 1'b1, 1'b0, 2);
    reset_mid_wait();

    for (int u = 0; u < NU; u++) begin
      for (int t = 0; t < 40; t++) begin
        p = 1'($urandom_range(0, 1));
        if ($urandom_range(0, 9) == 0) begin
          a = ($urandom_range(0, 1) == 0) ? 32'(32'h1000 + 4 * $urandom_range(0, 255))
                                          : 32'hFFFF_FFF0;
        end else begin
          a = 32'(($urandom_range(0, 63) << 2) | $urandom_range(0, 3));
        end
        s = ($urandom_range(0, 1) == 0) ? 4'h0 : 4'($urandom_range(1, 15));
        do_access(u, p, a, $urandom, s, $urandom_range(0, 3) == 0);
      end
    end

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule

// File: doc/vigna_bus_ram.md
VIGNA_BUS_RAM -- requirements
Module: vigna_bus_ram

Interface
REQ-001 SHALL have parameter DEPTH_WORDS, default 1024, number of 32-bit words (power of two, 16..65536).
REQ-002 SHALL have parameter BASE_ADDR, default 32'h0000_0000, byte address of word 0 (DEPTH_WORDS*4 aligned).
REQ-003 SHALL have parameter LATENCY, default 1, extra wait cycles per access (0..15).
REQ-004 SHALL have port clk  input  1  sole clock, rising edge.
REQ-005 SHALL have port resetn  input  1  reset; one clock; reset is asynchronous and active-low.
REQ-006 SHALL have ports i_valid/i_addr[31:0]/i_wdata[31:0]/i_wstrb[3:0] inputs; i_ready output 1; i_rdata output 32: instruction-side responder.
REQ-007 SHALL have ports d_valid/d_addr[31:0]/d_wdata[31:0]/d_wstrb[3:0] inputs; d_ready output 1; d_rdata output 32: data-side responder.
REQ-008 SHALL have port err  output  1  one-cycle pulse with the ready of an out-of-range access.

Function
REQ-009 Request pending on a port SHALL mean valid high; requester holds addr/wdata/wstrb stable until ready seen.
REQ-010 ready SHALL be a single-cycle pulse per accepted request, never two consecutive cycles on one port.
REQ-011 FSM SHALL have states IDLE, WAIT, RESP; one access in flight across both ports.
REQ-012 IDLE: on the edge with any valid high, SHALL grant one port, latch its addr/wdata/wstrb/port-id, load counter with LATENCY, go WAIT (LATENCY>0) or RESP (LATENCY=0).
REQ-013 WAIT: counter SHALL decrement each cycle; at 1 transition to RESP.
REQ-014 RESP: granted port's ready SHALL be high exactly this cycle, i.e. grant edge + LATENCY + 1 cycles; next state IDLE.
REQ-015 Both valid in IDLE: SHALL grant the port not granted last (round-robin); loser stays pending, granted at the next IDLE.
REQ-016 Word index SHALL be (addr - BASE_ADDR) >> 2; addr[1:0] ignored; in range iff index < DEPTH_WORDS (unsigned, wrap of subtraction counts as out of range).
REQ-017 wstrb == 0 SHALL be a read: rdata of granted port = memory word, valid in the ready cycle.
REQ-018 wstrb != 0 SHALL be a write: byte lane k updated from wdata[8k+7:8k] iff wstrb[k], committed on the edge ending the RESP cycle; rdata unchanged.
REQ-019 Out-of-range access SHALL still complete with ready per REQ-014; reads return 32'h0; writes discarded; err high in the RESP cycle.
REQ-020 rdata of each port SHALL hold its last value outside its ready cycle; the other port's rdata SHALL not change.
REQ-021 valid dropping before ready SHALL not abort the latched access; it completes, and ready is still pulsed.
REQ-022 valid seen in the RESP cycle on the just-served port SHALL not start a new request; the first IDLE cycle re-evaluates.

Reset
REQ-023 resetn low SHALL asynchronously force: i_ready=0, d_ready=0, err=0, i_rdata=0, d_rdata=0, FSM=IDLE, counter=0, last-grant=d (so i wins first tie).
REQ-024 Reset mid-access SHALL drop the access: no ready, no write commit; memory contents SHALL not be cleared by reset.
REQ-025 First grant SHALL occur no earlier than the first rising edge after resetn deasserts.

Structure
REQ-026 Shared package vigna_pkg SHALL hold the FSM state encoding, the port-id encoding (PORT_I, PORT_D) and the 4-bit latency counter width.
REQ-027 Storage SHALL be one sub-module vigna_bus_ram_array: single-port, synchronous, byte-write-enable, DEPTH_WORDS x 32, no reset.
REQ-028 Only the top SHALL contain arbitration, FSM, range check, and response registers.

Verification
REQ-029 LATENCY=1: d write 0xDEADBEEF to 0x10, wstrb 4'hF, then i read 0x10 -> i_ready at grant+2, i_rdata=0xDEADBEEF.
REQ-030 Byte strobes: word 0x20=0x11223344, d write 0xAABBCCDD wstrb 4'b0101 -> read back 0x11BB33DD.
REQ-031 i_valid and d_valid rise same cycle after reset -> i served first, d served next IDLE; repeat tie -> d then i alternate.
REQ-032 DEPTH_WORDS=1024, d read 0x1000 -> d_ready pulses, d_rdata=0, err=1 one cycle; write there leaves word 0 unchanged.
REQ-033 LATENCY=3, resetn low during WAIT -> no ready, target word unchanged, next access after release served normally.
REQ-034 LATENCY=0, back-to-back i reads 0x0,0x4 with valid held -> ready pulses never consecutive, one per request.
